// File: rtl/lcd_temp_writer.sv
// Streams "T=sddd.d°C" plus a DDRAM-address command to the HD44780 controller
// on each refresh tick, converting the held temperature sample with a serial double-dabble.
module lcd_temp_writer #(
  parameter int unsigned REFRESH_CYCLES = 24000000,
  parameter logic [7:0]  LINE_ADDR      = 8'h80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        temp_valid,
  input  logic [12:0] temp_data,
  input  logic        lcd_rdy,
  output logic        lcd_req,
  output logic        lcd_rs,
  output logic [7:0]  lcd_data,
  output logic        busy
);

  localparam int CW = $clog2(REFRESH_CYCLES);

  typedef enum logic [1:0] {IDLE, CONV, SEND, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic          tick;
  logic [12:0]   sample_reg;
  logic          have_sample;
  logic          pending;
  logic          start;
  logic [12:0]   mag;
  logic [8:0]    bin;
  logic [11:0]   bcd, bcd_adj;
  logic [3:0]    frac, tenths, step, idx;
  logic [7:0]    frac_x10;
  logic          sign;
  logic          gap_cnt;
  logic [3:0]    dig_h, dig_t, dig_o;

  assign tick     = (count == CW'(REFRESH_CYCLES - 1));
  assign start    = (state == IDLE) && pending && have_sample;
  assign mag      = sample_reg[12] ? (~sample_reg + 13'd1) : sample_reg;
  assign frac_x10 = {1'b0, frac, 3'b000} + {3'b000, frac, 1'b0};
  assign dig_h    = bcd[11:8];
  assign dig_t    = bcd[7:4];
  assign dig_o    = bcd[3:0];
  assign busy     = (state != IDLE);

  // A tick wins over the clear, so a tick landing on the frame-start cycle queues another frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      pending     <= 1'b0;
      sample_reg  <= '0;
      have_sample <= 1'b0;
    end else begin
      count <= tick ? '0 : count + CW'(1);
      if (tick)
        pending <= 1'b1;
      else if (start)
        pending <= 1'b0;
      if (temp_valid) begin
        sample_reg  <= temp_data;
        have_sample <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Transfer handshake: lcd_req is asserted only in SEND with lcd_rs/lcd_data held
  // constant; the byte is consumed on the clk edge where lcd_req && lcd_rdy.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (step == 4'd9) state_nxt = SEND;
      SEND:    if (lcd_rdy) state_nxt = GAP;
      GAP:     if (gap_cnt) state_nxt = (idx == 4'd10) ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin     <= '0;
      bcd     <= '0;
      frac    <= '0;
      tenths  <= '0;
      step    <= '0;
      idx     <= '0;
      sign    <= 1'b0;
      gap_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sign <= sample_reg[12];
          bin  <= mag[12:4];
          frac <= mag[3:0];
          bcd  <= '0;
          step <= '0;
        end
        CONV: begin
          step <= step + 4'd1;
          if (step == 4'd9) begin
            tenths <= frac_x10[7:4];
            idx    <= '0;
          end else begin
            bcd <= {bcd_adj[10:0], bin[8]};
            bin <= {bin[7:0], 1'b0};
          end
        end
        SEND: gap_cnt <= 1'b0;
        GAP: begin
          gap_cnt <= ~gap_cnt;
          if (gap_cnt && idx != 4'd10) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lcd_req  = 1'b0;
    lcd_rs   = 1'b0;
    lcd_data = 8'h00;
    if (state == SEND) begin
      lcd_req = 1'b1;
      lcd_rs  = 1'b1;
      case (idx)
        4'd0: begin
          lcd_rs   = 1'b0;
          lcd_data = LINE_ADDR;
        end
        4'd1:    lcd_data = 8'h54;
        4'd2:    lcd_data = 8'h3D;
        4'd3:    lcd_data = sign ? 8'h2D : 8'h2B;
        4'd4:    lcd_data = (dig_h == 4'd0) ? 8'h20 : {4'h3, dig_h};
        4'd5:    lcd_data = (dig_h == 4'd0 && dig_t == 4'd0) ? 8'h20 : {4'h3, dig_t};
        4'd6:    lcd_data = {4'h3, dig_o};
        4'd7:    lcd_data = 8'h2E;
        4'd8:    lcd_data = {4'h3, tenths};
        4'd9:    lcd_data = 8'hDF;
        default: lcd_data = 8'h43;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_temp_writer.sv
// Bench for lcd_temp_writer: reset, no-sample, table frames, stall, mid-frame reset,
// then random samples and lcd_rdy against an arithmetic model of the displayed string.
module tb_lcd_temp_writer;

  logic        clk;
  logic        reset;
  logic        temp_valid;
  logic [12:0] temp_data;
  logic        lcd_rdy;
  logic        lcd_req;
  logic        lcd_rs;
  logic [7:0]  lcd_data;
  logic        busy;

  lcd_temp_writer #(.REFRESH_CYCLES(200), .LINE_ADDR(8'h80)) dut (
    .clk(clk), .reset(reset), .temp_valid(temp_valid), .temp_data(temp_data),
    .lcd_rdy(lcd_rdy), .lcd_req(lcd_req), .lcd_rs(lcd_rs), .lcd_data(lcd_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] temp;
    logic [79:0] chars;
  } vec_t;

  vec_t        vecs[5];
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];
  logic [12:0] model_sample;
  logic        busy_prev;
  logic        in_gap;
  int          low_run;
  int          busy_rises;
  int          total;
  int          bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Expected display string from plain arithmetic on the signed sample.
  function automatic void push_frame(input logic [12:0] s);
    int v, mg, ip, ten, h, t, o;
    v   = s[12] ? int'(s) - 8192 : int'(s);
    mg  = (v < 0) ? -v : v;
    ip  = mg / 16;
    ten = ((mg % 16) * 10) / 16;
    h   = ip / 100;
    t   = (ip / 10) % 10;
    o   = ip % 10;
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b1, 8'h54});
    exp_q.push_back({1'b1, 8'h3D});
    exp_q.push_back({1'b1, (v < 0) ? 8'h2D : 8'h2B});
    exp_q.push_back({1'b1, (h == 0) ? 8'h20 : 8'(48 + h)});
    exp_q.push_back({1'b1, (h == 0 && t == 0) ? 8'h20 : 8'(48 + t)});
    exp_q.push_back({1'b1, 8'(48 + o)});
    exp_q.push_back({1'b1, 8'h2E});
    exp_q.push_back({1'b1, 8'(48 + ten)});
    exp_q.push_back({1'b1, 8'hDF});
    exp_q.push_back({1'b1, 8'h43});
  endfunction

  // One clock: inputs set at the negedge before, outputs examined at the negedge after.
  task automatic cycle();
    logic        xfer, hold_chk, was_reset;
    logic [8:0]  xword;
    logic [12:0] sample_before;
    was_reset     = reset;
    xfer          = lcd_req && lcd_rdy && !reset;
    hold_chk      = lcd_req && !lcd_rdy && !reset;
    xword         = {lcd_rs, lcd_data};
    sample_before = model_sample;
    if (reset) model_sample = '0;
    else if (temp_valid) model_sample = temp_data;
    @(posedge clk);
    @(negedge clk);
    temp_valid = 1'b0;
    if (was_reset) in_gap = 1'b0;
    if (busy && !busy_prev) begin
      busy_rises++;
      push_frame(sample_before);
    end
    busy_prev = busy;
    if (hold_chk) begin
      check("hold_req", 32'(lcd_req), 32'd1);
      check("hold_byte", 32'({lcd_rs, lcd_data}), 32'(xword));
    end
    if (xfer) begin
      got_q.push_back(xword);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_xfer: got %0h expected none", xword);
      end else begin
        check("xfer", 32'(xword), 32'(exp_q.pop_front()));
      end
      in_gap  = 1'b1;
      low_run = 0;
    end
    if (in_gap) begin
      if (lcd_req || !busy) begin
        check("gap_len", 32'(low_run), 32'd2);
        in_gap = 1'b0;
      end else begin
        low_run++;
      end
    end
  endtask

  task automatic wait_frame(input int budget);
    bit started;
    int n;
    started = busy;
    n = 0;
    while (!(started && !busy) && n < budget) begin
      cycle();
      if (busy) started = 1'b1;
      n++;
    end
    check("frame_done", 32'(started && !busy), 32'd1);
  endtask

  task automatic compare_frame(input string name, input logic [79:0] chars);
    logic [8:0] want;
    logic [8:0] got;
    check({name, "_len"}, 32'(got_q.size()), 32'd11);
    for (int k = 0; k < 11; k++) begin
      want = (k == 0) ? {1'b0, 8'h80} : {1'b1, chars[(10-k)*8 +: 8]};
      got  = (k < got_q.size()) ? got_q[k] : 9'h1FF;
      check(name, 32'(got), 32'(want));
    end
  endtask

  initial begin
    int rises0, req_seen, stable_n, n;
    vecs[0] = '{13'h0190, 80'h543D2B2032352E30DF43};
    vecs[1] = '{13'h1F58, 80'h543D2D2031302E35DF43};
    vecs[2] = '{13'h000F, 80'h543D2B2020302E39DF43};
    vecs[3] = '{13'h1000, 80'h543D2D3235362E30DF43};
    vecs[4] = '{13'h0961, 80'h543D2B3135302E30DF43};
    total = 0; bad = 0; busy_rises = 0; busy_prev = 1'b0; in_gap = 1'b0; low_run = 0;
    model_sample = '0;
    reset = 1'b1; temp_valid = 1'b0; temp_data = '0; lcd_rdy = 1'b1;

    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    check("rst_req", 32'(lcd_req), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_data", 32'(lcd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // No sample: ticks arrive but nothing is sent.
    rises0 = busy_rises; req_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (lcd_req) req_seen++;
    end
    check("nosample_frames", 32'(busy_rises - rises0), 32'd0);
    check("nosample_req", 32'(req_seen), 32'd0);

    for (int i = 0; i < 5; i++) begin
      got_q.delete();
      temp_data = vecs[i].temp; temp_valid = 1'b1;
      cycle();
      wait_frame(600);
      compare_frame("table", vecs[i].chars);
    end

    // Stall with idx4 pending for longer than one refresh period.
    got_q.delete();
    temp_data = 13'h0190; temp_valid = 1'b1;
    cycle();
    n = 0;
    while (got_q.size() < 4 && n < 600) begin cycle(); n++; end
    check("stall_reach", 32'(got_q.size()), 32'd4);
    lcd_rdy = 1'b0;
    stable_n = 0;
    for (int i = 0; i < 210; i++) begin
      cycle();
      if (lcd_req && lcd_rs && lcd_data == 8'h20) stable_n++;
    end
    check("stall_held", 32'(stable_n), 32'd209);
    check("stall_no_xfer", 32'(got_q.size()), 32'd4);
    lcd_rdy = 1'b1;
    wait_frame(600);
    compare_frame("stall", vecs[0].chars);
    check("stall_idle", 32'(busy), 32'd0);
    cycle();
    check("stall_next_frame", 32'(busy), 32'd1);
    got_q.delete();
    wait_frame(600);
    compare_frame("after_stall", vecs[0].chars);

    // Reset while idx6 is the next transfer.
    got_q.delete();
    n = 0;
    while (got_q.size() < 6 && n < 600) begin cycle(); n++; end
    check("reset_reach", 32'(got_q.size()), 32'd6);
    reset = 1'b1;
    cycle();
    check("midrst_req", 32'(lcd_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(lcd_data), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    rises0 = busy_rises;
    for (int i = 0; i < 450; i++) cycle();
    check("postrst_frames", 32'(busy_rises - rises0), 32'd0);
    got_q.delete();
    temp_data = 13'h1F58; temp_valid = 1'b1;
    cycle();
    wait_frame(600);
    compare_frame("postrst", vecs[1].chars);

    // Random samples and flow control against the model.
    for (int i = 0; i < 5000; i++) begin
      lcd_rdy = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 3) begin
        temp_valid = 1'b1;
        temp_data  = 13'($urandom_range(0, 8191));
      end
      cycle();
    end
    lcd_rdy = 1'b1;
    n = 0;
    while (busy && n < 600) begin cycle(); n++; end
    check("rand_idle", 32'(busy), 32'd0);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
